// File: rtl/register_file_dump_pkg.sv
// Purpose : shared sizes, types and dump FSM encoding for the register file.
// Latency : n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
// Contents: WIDTH/NREGS/AW, word/address/array types, dump state enum,
//           fwd_read() write-first read helper used by every read path.
package register_file_dump_pkg;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [WIDTH-1:0]            word_t;
  typedef logic [AW-1:0]               addr_t;
  typedef logic [NREGS-1:0][WIDTH-1:0] reg_arr_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_e;

  // Write-first read: a write landing on the same address this cycle is
  // forwarded, and address 0 always reads zero regardless of the write port.
  function automatic word_t fwd_read(addr_t addr, logic ld, addr_t rw,
                                     word_t pw, reg_arr_t regs);
    word_t r;
    r = regs[addr];
    if (ld && (rw == addr)) r = pw;
    if (addr == '0)         r = '0;
    return r;
  endfunction

endpackage

// File: rtl/register_file_dump_if.sv
// Purpose : bundles the write/read ports and the dump stream of the register file.
// Latency : n/a (wiring only).
// Backpressure: dump stream is valid/ready; dump_valid never depends on dump_ready.
// Ports   : master = CPU/monitor side (drives Ld/RW/PW/RA/RB/dump_start/dump_ready),
//           slave  = register file side (drives PA/PB/dump_valid/addr/data/busy).
interface register_file_dump_if;

  logic                          Ld;
  register_file_dump_pkg::addr_t RW;
  register_file_dump_pkg::word_t PW;
  register_file_dump_pkg::addr_t RA;
  register_file_dump_pkg::addr_t RB;
  register_file_dump_pkg::word_t PA;
  register_file_dump_pkg::word_t PB;
  logic                          dump_start;
  logic                          dump_ready;
  logic                          dump_valid;
  register_file_dump_pkg::addr_t dump_addr;
  register_file_dump_pkg::word_t dump_data;
  logic                          dump_busy;

  modport master (
    output Ld, RW, PW, RA, RB, dump_start, dump_ready,
    input  PA, PB, dump_valid, dump_addr, dump_data, dump_busy
  );

  modport slave (
    input  Ld, RW, PW, RA, RB, dump_start, dump_ready,
    output PA, PB, dump_valid, dump_addr, dump_data, dump_busy
  );

endinterface

// File: rtl/register_file_dump_reg32_ar.sv
// Purpose : one WIDTH-bit storage register with load enable and async clear.
// Latency : 1 clock from ld/d to q.
// Backpressure: none; loads whenever ld is high.
// Ports   : clk, reset (async active-high clear), ld (load enable),
//           d (load data), q (stored value).
module reg32_ar
  import register_file_dump_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  ld,
  input  word_t d,
  output word_t q
);

  word_t val_d;
  word_t val_q;

  always_comb begin
    val_d = val_q;
    if (ld) val_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) val_q <= '0;
    else       val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/register_file_dump.sv
// Purpose : 32x32 register file, R0 = 0, two write-first comb read ports, plus a
//           sequential dump streamer. Latency: write 1 edge, read 0, dump NREGS beats.
// Backpressure: dump beat (addr/data) holds while dump_ready=0; data is a snapshot.
// Ports   : clk, reset (async active-high), bus (register_file_dump_if.slave):
//           Ld/RW/PW write, RA/RB -> PA/PB reads, dump_start/ready/valid/addr/data/busy.
module register_file_dump
  import register_file_dump_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  register_file_dump_if.slave     bus
);

  // ---------------------------------------------------------------- storage
  reg_arr_t regs;

  assign regs[0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    logic ld_i;
    assign ld_i = bus.Ld && (bus.RW == addr_t'(i));
    reg32_ar u_reg (
      .clk   (clk),
      .reset (reset),
      .ld    (ld_i),
      .d     (bus.PW),
      .q     (regs[i])
    );
  end

  // ---------------------------------------------------------- operand reads
  assign bus.PA = fwd_read(bus.RA, bus.Ld, bus.RW, bus.PW, regs);
  assign bus.PB = fwd_read(bus.RB, bus.Ld, bus.RW, bus.PW, regs);

  // --------------------------------------------------------------- dump FSM
  dump_state_e state_d, state_q;
  addr_t       idx_d,   idx_q;
  word_t       data_d,  data_q;
  addr_t       idx_nxt;
  logic        dump_valid;
  logic        dump_busy;

  assign idx_nxt = idx_q + addr_t'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dump_start) begin
          state_d = SEND;
          idx_d   = '0;
          data_d  = '0;   // beat 0 is R0
        end
      end
      SEND: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        if (bus.dump_ready) begin
          if (idx_q == addr_t'(NREGS - 1)) begin
            state_d = IDLE;
          end else begin
            idx_d  = idx_nxt;
            // Capture the value the register holds after this edge, so a
            // write to the next index in the accept cycle is included.
            data_d = fwd_read(idx_nxt, bus.Ld, bus.RW, bus.PW, regs);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign bus.dump_valid = dump_valid;
  assign bus.dump_busy  = dump_busy;
  assign bus.dump_addr  = idx_q;
  assign bus.dump_data  = data_q;

endmodule

// File: tb/tb_register_file_dump.sv
// Purpose : randomized self-checking bench for register_file_dump against an array model.
// Latency : inputs change 1ns after posedge, outputs sampled 1ns later.
// Backpressure: dump_ready driven randomly or held per scenario.
module tb_register_file_dump;
  import register_file_dump_pkg::*;

  logic clk;
  logic reset;

  register_file_dump_if bus();

  register_file_dump dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;

  // Architectural model: register contents plus the beat currently offered.
  word_t model_reg [NREGS];
  bit    d_active;
  int    d_addr;
  word_t d_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic word_t exp_read(int a);
    if (a == 0) return '0;
    if (bus.Ld && int'(bus.RW) == a) return bus.PW;
    return model_reg[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) model_reg[i] = '0;
    d_active = 1'b0;
    d_addr   = 0;
    d_data   = '0;
  endtask

  task automatic idle_inputs();
    bus.Ld         = 1'b0;
    bus.RW         = '0;
    bus.PW         = '0;
    bus.RA         = '0;
    bus.RB         = '0;
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b0;
  endtask

  // Advance one clock edge, updating the model with what that edge does.
  task automatic edge_step();
    if (!reset) begin
      if (bus.Ld && bus.RW != 0) model_reg[bus.RW] = bus.PW;
      if (d_active) begin
        if (bus.dump_ready) begin
          if (d_addr == NREGS - 1) d_active = 1'b0;
          else begin
            d_addr++;
            d_data = model_reg[d_addr];   // snapshot of value after this edge
          end
        end
      end else if (bus.dump_start) begin
        d_active = 1'b1;
        d_addr   = 0;
        d_data   = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reads(input string tag);
    check_eq({tag, "_PA"}, bus.PA, exp_read(int'(bus.RA)));
    check_eq({tag, "_PB"}, bus.PB, exp_read(int'(bus.RB)));
  endtask

  task automatic check_dump(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.dump_valid), 32'(d_active));
    check_eq({tag, "_busy"},  32'(bus.dump_busy),  32'(d_active));
    if (d_active) begin
      check_eq({tag, "_addr"}, 32'(bus.dump_addr), 32'(d_addr));
      check_eq({tag, "_data"}, bus.dump_data, d_data);
    end
  endtask

  // Asynchronous reset applied away from the clock edge.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    clear_model();
    check_eq({tag, "_valid"}, 32'(bus.dump_valid), 32'd0);
    check_eq({tag, "_busy"},  32'(bus.dump_busy),  32'd0);
    check_eq({tag, "_addr"},  32'(bus.dump_addr),  32'd0);
    check_eq({tag, "_data"},  bus.dump_data,       32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t old_v;
    word_t new_v;
    int    guard;

    reset = 1'b1;
    idle_inputs();
    clear_model();
    #1;
    check_eq("rst_valid", 32'(bus.dump_valid), 32'd0);
    check_eq("rst_busy",  32'(bus.dump_busy),  32'd0);
    check_eq("rst_addr",  32'(bus.dump_addr),  32'd0);
    check_eq("rst_data",  bus.dump_data,       32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // All addresses read zero after reset.
    for (int i = 0; i < NREGS; i++) begin
      bus.RA = addr_t'(i);
      bus.RB = addr_t'(NREGS - 1 - i);
      #1;
      check_eq("rst_sweep_PA", bus.PA, 32'd0);
      check_eq("rst_sweep_PB", bus.PB, 32'd0);
    end
    @(posedge clk);
    #1;

    // Plain write, then a discarded write to R0.
    bus.Ld = 1'b1; bus.RW = 5'd5; bus.PW = 32'h12345678;
    edge_step();
    bus.Ld = 1'b0; bus.RA = 5'd5;
    #1;
    check_eq("wr_r5", bus.PA, 32'h12345678);
    bus.Ld = 1'b1; bus.RW = 5'd0; bus.PW = 32'hFFFFFFFF;
    edge_step();
    bus.Ld = 1'b0; bus.RA = 5'd0;
    #1;
    check_eq("wr_r0", bus.PA, 32'h0);

    // Same-cycle bypass, then the same value through the array.
    bus.Ld = 1'b1; bus.RW = 5'd7; bus.PW = 32'hDEADBEEF; bus.RA = 5'd7; bus.RB = 5'd7;
    #1;
    check_eq("byp_PA", bus.PA, 32'hDEADBEEF);
    check_eq("byp_PB", bus.PB, 32'hDEADBEEF);
    edge_step();
    bus.Ld = 1'b0;
    #1;
    check_eq("byp_arr_PA", bus.PA, 32'hDEADBEEF);

    // Random traffic; half the reads aim at the write address.
    for (int c = 0; c < 300; c++) begin
      bus.Ld = 1'($urandom);
      bus.RW = 5'($urandom);
      bus.PW = $urandom;
      bus.RA = ($urandom_range(0, 1) == 0) ? bus.RW : 5'($urandom);
      bus.RB = 5'($urandom);
      #1;
      check_reads("rand");
      edge_step();
    end

    // Reset after writes clears the array.
    bus.Ld = 1'b1; bus.RW = 5'd5; bus.PW = 32'hA5A5A5A5;
    edge_step();
    bus.Ld = 1'b0; bus.RA = 5'd5;
    #1;
    check_eq("pre_rst_r5", bus.PA, 32'hA5A5A5A5);
    apply_reset("mid_rst");
    bus.RA = 5'd5;
    #1;
    check_eq("post_rst_r5", bus.PA, 32'h0);

    // Fill reg[i] = i * 0x11111111.
    for (int i = 1; i < NREGS; i++) begin
      bus.Ld = 1'b1; bus.RW = addr_t'(i); bus.PW = word_t'(i * 32'h11111111);
      edge_step();
    end
    bus.Ld = 1'b0;

    // Full-rate dump with ignored restarts (mid-dump and on the final accept).
    bus.dump_ready = 1'b1;
    bus.dump_start = 1'b1;
    edge_step();
    for (int n = 0; n < NREGS; n++) begin
      bus.dump_start = (n == 10 || n == NREGS - 1);
      #1;
      check_dump("dump");
      check_eq("dump_beat_addr", 32'(bus.dump_addr), 32'(n));
      check_eq("dump_beat_data", bus.dump_data, word_t'(n * 32'h11111111));
      edge_step();
    end
    bus.dump_start = 1'b0;
    #1;
    check_eq("dump_end_busy",  32'(bus.dump_busy),  32'd0);
    check_eq("dump_end_valid", 32'(bus.dump_valid), 32'd0);

    // Backpressure at beat 4 with writes to R4, then forwarding into beat 5.
    bus.dump_start = 1'b1;
    edge_step();
    bus.dump_start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      #1;
      check_dump("bp_pre");
      edge_step();
    end
    check_eq("bp_at4_addr", 32'(bus.dump_addr), 32'd4);
    old_v = d_data;
    bus.dump_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      bus.Ld = 1'b1; bus.RW = 5'd4; bus.PW = $urandom | 32'h1;
      #1;
      check_dump("bp_stall");
      check_eq("bp_hold_data", bus.dump_data, old_v);
      edge_step();
    end
    new_v = $urandom ^ 32'h5A5A0000;
    bus.Ld = 1'b1; bus.RW = 5'd5; bus.PW = new_v; bus.dump_ready = 1'b1;
    #1;
    check_dump("bp_accept");
    edge_step();
    bus.Ld = 1'b0;
    #1;
    check_eq("bp_beat5_addr", 32'(bus.dump_addr), 32'd5);
    check_eq("bp_beat5_data", bus.dump_data, new_v);

    // Rest of the dump under random ready and random writes.
    guard = 0;
    while (d_active && guard < 400) begin
      bus.dump_ready = 1'($urandom);
      bus.Ld = 1'($urandom);
      bus.RW = 5'($urandom);
      bus.PW = $urandom;
      bus.dump_start = 1'($urandom);
      #1;
      check_dump("bp_rand");
      edge_step();
      guard++;
    end
    bus.Ld = 1'b0;
    bus.dump_start = 1'b0;
    #1;
    check_eq("bp_done_busy", 32'(bus.dump_busy), 32'd0);

    // Reset at beat 10 aborts the dump; the next dump streams zeros.
    bus.dump_ready = 1'b1;
    bus.dump_start = 1'b1;
    edge_step();
    bus.dump_start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1;
      check_dump("abort_pre");
      edge_step();
    end
    check_eq("abort_at10_addr", 32'(bus.dump_addr), 32'd10);
    #2;
    apply_reset("abort_rst");
    bus.dump_start = 1'b1;
    edge_step();
    bus.dump_start = 1'b0;
    for (int n = 0; n < NREGS; n++) begin
      #1;
      check_dump("redump");
      check_eq("redump_addr", 32'(bus.dump_addr), 32'(n));
      check_eq("redump_zero", bus.dump_data, 32'd0);
      edge_step();
    end
    #1;
    check_eq("redump_end_busy", 32'(bus.dump_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_dump.md
# register_file_dump

Register file for the CPU datapath: 32 × 32-bit general registers with one synchronous write port and two combinational read ports (rs/rt operand fetch). R0 is hardwired to zero. It also contains a sequential dump reader that streams every register out over a valid/ready port, so the testbench and debug monitor can snapshot architectural state without stealing the operand read ports.

## Interface
- WIDTH, 32, register width in bits
- NREGS, 32, number of registers; address width is log2(NREGS) = 5

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all registers and the dump FSM
- Ld  in  1  write enable
- RW  in  5  write address
- PW  in  WIDTH  write data
- RA  in  5  read address, port A
- RB  in  5  read address, port B
- PA  out  WIDTH  read data, port A (combinational)
- PB  out  WIDTH  read data, port B (combinational)
- dump_start  in  1  one-cycle request to begin a dump
- dump_ready  in  1  consumer accepts the current beat
- dump_valid  out  1  dump beat present
- dump_addr  out  5  register index of the current beat
- dump_data  out  WIDTH  register value of the current beat
- dump_busy  out  1  dump FSM is not IDLE

## Operation
- Write: at a rising edge with Ld=1 and RW≠0, reg[RW] ← PW. Writes with RW=0 are discarded; reg[0] always reads 0.
- Read: PA = (RA==0) ? 0 : (Ld && RW==RA) ? PW : reg[RA]. This is a write-first bypass, so same-cycle forwarding from the write-back stage is visible. PB is identical using RB.
- Dump FSM states:
  - IDLE: dump_valid=0, dump_busy=0. On dump_start=1: idx←0, dump_data←0, dump_addr←0, go to SEND.
  - SEND: dump_valid=1, dump_busy=1.
    - On dump_valid && dump_ready with idx==NREGS-1: go to IDLE.
    - On dump_valid && dump_ready otherwise: idx←idx+1, and dump_data ← next value of reg[idx+1]. If Ld && RW==idx+1 && RW≠0 in that cycle, the next value is PW (write-first).
    - If dump_ready=0: hold dump_addr and dump_data stable.
- Snapshot semantics: a beat's data is captured when the beat is loaded. Later writes to that register while the beat is stalled do not alter dump_data.
- dump_start while in SEND is ignored; no restart.
- Reset values: all reg[i]=0; state IDLE; idx=0; dump_valid=0; dump_busy=0; dump_addr=0; dump_data=0. PA and PB therefore read 0 after reset.
- Reset asserted mid-dump aborts immediately (asynchronously). dump_valid drops with reset, and no partial beat remains after release.

## Timing
- Write latency: 1 edge. A value written at edge k appears on PA/PB via the array after edge k, and via the bypass during the cycle before edge k.
- Read latency: 0 cycles (combinational).
- Dump: dump_start sampled at edge k gives the first beat (R0) valid after edge k.
- With dump_ready held at 1, beat n is transferred at edge k+1+n, the last beat at edge k+NREGS, and dump_busy=0 after edge k+NREGS. The total is NREGS cycles with no bubbles.
- The consumer may not depend on dump_valid combinationally to drive dump_ready. dump_valid does not depend on dump_ready.
- dump_start arriving in the same cycle as the final accept is ignored: the FSM is still in SEND during that cycle.

## Structure
- Shared package: WIDTH, NREGS, address width, and dump FSM state encoding (IDLE=0, SEND=1).
- Sub-module reg32_ar: a 32-bit register with load enable and asynchronous active-high clear, instantiated NREGS-1 times (R1..R31). reg[0] is a constant 0.
- The dump FSM, idx counter and bypass muxes stay in the top module.

## Test plan
- Reset, then read all addresses: with RA, RB swept 0..31, PA=PB=0. Assert reset mid-run after writes, then read R5 → 0.
- Ld=1, RW=5, PW=32'h12345678 at edge, then RA=5 → PA=32'h12345678. Write RW=0, PW=32'hFFFFFFFF, then RA=0 → PA=0.
- Bypass: Ld=1, RW=7, PW=32'hDEADBEEF, RA=RB=7 in the same cycle → PA=PB=32'hDEADBEEF before the edge.
- Dump, ready=1, with reg[i]=i*32'h11111111:
  - 32 consecutive beats with dump_addr=0..31 and dump_data=reg[i] (beat 0 = 0).
  - dump_busy falls after the 32nd beat.
  - A second dump_start mid-dump is ignored.
- Dump backpressure:
  - dump_ready=0 for 3 cycles at beat 4 while writing RW=4 → dump_data holds the old value.
  - Writing RW=5 in the accept cycle → beat 5 carries the new PW.
- Reset asserted at beat 10 → dump_valid=0, dump_busy=0 immediately. A new dump_start after release restarts at dump_addr=0 with all data 0.
